executor_scheduler: RTL and testbench

EXECUTOR_SCHEDULER -- requirements
Module: executor_scheduler

---
 rtl/executor_scheduler.sv | 166 ++++++++++++++++
 tb/tb_executor_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/executor_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : executor_scheduler
// Brief    : Round-robin arbiter that starts one of four move executors (down,
//            rotate, left, right), runs gravity, and muxes the winner's writes.
// Revision : 1.0 - initial release
// ============================================================================

package executor_scheduler_pkg;
    typedef enum logic [2:0] {
        T_I = 3'd0,
        T_O = 3'd1,
        T_T = 3'd2,
        T_S = 3'd3,
        T_Z = 3'd4,
        T_J = 3'd5,
        T_L = 3'd6
    } tile_type_e;

    typedef struct packed {
        logic [3:0] x;
        logic [4:0] y;
    } point_t;
endpackage

module executor_scheduler
    import executor_scheduler_pkg::*;
#(
    parameter int gravity_period_p = 50_000_000,
    parameter int timeout_p        = 1024
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [3:0]             req_i,
    input  logic                   pause_i,
    output logic [3:0]             exec_v_o,
    input  logic [3:0]             exec_done_i,
    input  logic [3:0]             exec_set_v_i,
    input  tile_type_e [3:0]       exec_type_i,
    input  logic [3:0][1:0]        exec_angle_i,
    input  point_t [3:0]           exec_pos_i,
    output logic                   cm_set_v_o,
    output tile_type_e             cm_type_o,
    output logic [1:0]             cm_angle_o,
    output point_t                 cm_pos_o,
    output logic                   busy_o,
    output logic [1:0]             grant_o,
    output logic                   error_o
);

    localparam int              GRAV_W    = (gravity_period_p > 2) ? $clog2(gravity_period_p) : 1;
    localparam logic [GRAV_W-1:0] GRAV_LAST = GRAV_W'(gravity_period_p - 1);
    localparam int              WD_W      = $clog2(timeout_p);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(timeout_p - 1);

    typedef enum logic [1:0] {
        eIDLE  = 2'd0,
        eIssue = 2'd1,
        eBusy  = 2'd2
    } state_e;

    state_e            state_r, state_n;
    logic [3:0]        pend_r;
    logic [1:0]        rr_ptr_r;
    logic [1:0]        grant_r;
    logic [GRAV_W-1:0] grav_r;
    logic [WD_W-1:0]   wd_r;
    logic              error_r;

    logic              grav_tick;
    logic              pick_v;
    logic [1:0]        pick_idx;
    logic [1:0]        cand;
    logic              issue;
    logic              wd_expire;
    logic              grant_done;
    logic [3:0]        issue_mask;

    assign grav_tick  = !pause_i && (grav_r == GRAV_LAST);
    assign grant_done = exec_done_i[grant_r];
    assign issue_mask = issue ? (4'b0001 << pick_idx) : 4'b0000;

    // First pending source at or after the round-robin pointer wins.
    always_comb begin
        pick_v   = 1'b0;
        pick_idx = rr_ptr_r;
        cand     = rr_ptr_r;
        for (int i = 0; i < 4; i++) begin
            cand = rr_ptr_r + 2'(i);
            if (!pick_v && pend_r[cand]) begin
                pick_v   = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_n   = state_r;
        issue     = 1'b0;
        wd_expire = 1'b0;
        case (state_r)
            eIDLE: begin
                if (!pause_i && pick_v) begin
                    state_n = eIssue;
                    issue   = 1'b1;
                end
            end
            eIssue: begin
                state_n = grant_done ? eIDLE : eBusy;
            end
            eBusy: begin
                if (grant_done) begin
                    state_n = eIDLE;
                end else if (wd_r == WD_LAST) begin
                    state_n   = eIDLE;
                    wd_expire = 1'b1;
                end
            end
            default: state_n = eIDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= eIDLE;
            pend_r   <= 4'b0000;
            rr_ptr_r <= 2'd0;
            grant_r  <= 2'd0;
            grav_r   <= '0;
            wd_r     <= '0;
            error_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            // A request landing on its own issue cycle survives the clear.
            pend_r  <= (pend_r & ~issue_mask) | req_i | {3'b000, grav_tick};
            if (!pause_i) begin
                grav_r <= (grav_r == GRAV_LAST) ? '0 : grav_r + GRAV_W'(1);
            end
            if (issue) begin
                grant_r  <= pick_idx;
                rr_ptr_r <= pick_idx + 2'd1;
            end
            if (state_r == eBusy && state_n == eBusy) begin
                wd_r <= wd_r + WD_W'(1);
            end else begin
                wd_r <= '0;
            end
            if (wd_expire) begin
                error_r <= 1'b1;
            end
        end
    end

    // Strobes are gated by reset so a reset landing mid-issue emits nothing.
    assign exec_v_o   = (state_r == eIssue && !reset_i) ? (4'b0001 << grant_r) : 4'b0000;
    assign cm_set_v_o = (state_r != eIDLE) && !reset_i && exec_set_v_i[grant_r];
    assign cm_type_o  = exec_type_i[grant_r];
    assign cm_angle_o = exec_angle_i[grant_r];
    assign cm_pos_o   = exec_pos_i[grant_r];
    assign busy_o     = (state_r != eIDLE);
    assign grant_o    = grant_r;
    assign error_o    = error_r;

endmodule

`default_nettype wire

// File: tb/tb_executor_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_executor_scheduler
// Brief    : Directed self-checking bench for executor_scheduler.
// Revision : 1.0 - initial release
// ============================================================================

module tb_executor_scheduler;
    import executor_scheduler_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, pause;
    logic [3:0]       req, exec_done, exec_set_v, exec_v;
    tile_type_e [3:0] exec_type;
    logic [3:0][1:0]  exec_angle;
    point_t [3:0]     exec_pos;
    logic             cm_set_v;
    tile_type_e       cm_type;
    logic [1:0]       cm_angle;
    point_t           cm_pos;
    logic             busy, error;
    logic [1:0]       grant;

    logic             reset_g, pause_g;
    logic [3:0]       req_g, exec_v_g, exec_done_g, exec_set_v_g;
    tile_type_e [3:0] exec_type_g;
    logic [3:0][1:0]  exec_angle_g;
    point_t [3:0]     exec_pos_g;
    logic             cm_set_v_g, busy_g, error_g;
    tile_type_e       cm_type_g;
    logic [1:0]       cm_angle_g, grant_g;
    point_t           cm_pos_g;

    executor_scheduler #(.gravity_period_p(100000), .timeout_p(4)) dut (
        .clk_i(clk), .reset_i(reset), .req_i(req), .pause_i(pause),
        .exec_v_o(exec_v), .exec_done_i(exec_done), .exec_set_v_i(exec_set_v),
        .exec_type_i(exec_type), .exec_angle_i(exec_angle), .exec_pos_i(exec_pos),
        .cm_set_v_o(cm_set_v), .cm_type_o(cm_type), .cm_angle_o(cm_angle),
        .cm_pos_o(cm_pos), .busy_o(busy), .grant_o(grant), .error_o(error)
    );

    // Gravity-only instance: every start is completed in its issue cycle.
    assign req_g        = 4'b0000;
    assign exec_done_g  = exec_v_g;
    assign exec_set_v_g = 4'b0000;
    assign exec_type_g  = '0;
    assign exec_angle_g = '0;
    assign exec_pos_g   = '0;

    executor_scheduler #(.gravity_period_p(8), .timeout_p(1024)) dut_g (
        .clk_i(clk), .reset_i(reset_g), .req_i(req_g), .pause_i(pause_g),
        .exec_v_o(exec_v_g), .exec_done_i(exec_done_g), .exec_set_v_i(exec_set_v_g),
        .exec_type_i(exec_type_g), .exec_angle_i(exec_angle_g), .exec_pos_i(exec_pos_g),
        .cm_set_v_o(cm_set_v_g), .cm_type_o(cm_type_g), .cm_angle_o(cm_angle_g),
        .cm_pos_o(cm_pos_g), .busy_o(busy_g), .grant_o(grant_g), .error_o(error_g)
    );

    int checks = 0;
    int errors = 0;
    int sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait for the next start pulse, then score it against the queue head.
    task automatic await_issue(input string tag, output int e, output int n);
        n = 0;
        e = 0;
        while (exec_v == 4'b0000 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, 32'(exec_v != 4'b0000), 32'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_unexpected"}, 32'(exec_v), 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_exec_v"}, 32'(exec_v), 32'(1 << e));
            check({tag, "_grant"}, 32'(grant), 32'(e));
        end
    endtask

    task automatic next_pulse_g(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (exec_v_g == 4'b0000 && n < 40);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int e, n;

    initial begin
        reset = 1'b1; pause = 1'b0; req = '0; exec_done = '0; exec_set_v = '0;
        reset_g = 1'b1; pause_g = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exec_type[i]  = tile_type_e'(i + 1);
            exec_angle[i] = 2'(i);
            exec_pos[i]   = '{x: 4'(i + 2), y: 5'(i + 5)};
        end

        tick();
        check("rst_exec_v", 32'(exec_v), 32'd0);
        check("rst_cm_set_v", 32'(cm_set_v), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_exec_v", 32'(exec_v), 32'd0);
        check("post_rst_grant", 32'(grant), 32'd0);
        check("post_rst_error", 32'(error), 32'd0);

        // Single rotate with payload mux and ignored foreign done
        sb_q.push_back(1);
        req = 4'b0010;
        tick();
        check("t1_not_yet_busy", 32'(busy), 32'd0);
        req = 4'b0000;
        tick();
        await_issue("t1", e, n);
        check("t1_latency", 32'(n), 32'd0);
        exec_set_v = 4'b0011;
        #1;
        check("t1_cm_set_v", 32'(cm_set_v), 32'd1);
        check("t1_cm_type", 32'(cm_type), 32'(T_T));
        check("t1_cm_angle", 32'(cm_angle), 32'd1);
        check("t1_cm_pos", 32'(cm_pos), 32'({4'd3, 5'd6}));
        exec_set_v = 4'b0000;
        tick();
        check("t1_busy_d", 32'(busy), 32'd1);
        check("t1_pulse_once", 32'(exec_v), 32'd0);
        exec_done = 4'b0001;
        tick();
        check("t1_foreign_done", 32'(busy), 32'd1);
        exec_done = 4'b0010;
        tick();
        check("t1_done_idle", 32'(busy), 32'd0);
        exec_done = 4'b0000;

        // Fast completion during issue
        sb_q.push_back(1);
        req = 4'b0010;
        tick();
        req = 4'b0000;
        tick();
        await_issue("fast", e, n);
        exec_done = 4'b0010;
        tick();
        check("fast_idle", 32'(busy), 32'd0);
        exec_done = 4'b0000;
        tick();
        check("fast_no_pulse", 32'(exec_v), 32'd0);

        // Round-robin order 0,1,2,3 from a fresh pointer
        do_reset();
        for (int i = 0; i < 4; i++) sb_q.push_back(i);
        req = 4'b1111;
        tick();
        req = 4'b0000;
        tick();
        for (int i = 0; i < 4; i++) begin
            await_issue($sformatf("rr%0d", i), e, n);
            tick();
            tick();
            exec_done = 4'(1 << e);
            tick();
            exec_done = 4'b0000;
        end
        check("rr_no_error", 32'(error), 32'd0);

        // Watchdog timeout then the next pending source is served
        do_reset();
        sb_q.push_back(2);
        req = 4'b0100;
        tick();
        sb_q.push_back(3);
        req = 4'b1000;
        tick();
        req = 4'b0000;
        await_issue("to_first", e, n);
        check("to_first_latency", 32'(n), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("to_busy%0d", i), 32'({busy, error}), 32'b10);
        end
        tick();
        check("to_expired", 32'({busy, error}), 32'b01);
        await_issue("to_next", e, n);
        exec_done = 4'b1000;
        tick();
        exec_done = 4'b0000;
        check("to_sticky", 32'({busy, error}), 32'b01);

        // Pause does not abort the in-flight executor but blocks new grants
        do_reset();
        sb_q.push_back(0);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        await_issue("pz_first", e, n);
        pause = 1'b1;
        tick();
        check("pz_inflight", 32'(busy), 32'd1);
        exec_done = 4'b0001;
        tick();
        check("pz_done", 32'(busy), 32'd0);
        exec_done = 4'b0000;
        req = 4'b0010;
        tick();
        req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("pz_blocked%0d", i), 32'({busy, exec_v}), 32'd0);
        end
        sb_q.push_back(1);
        pause = 1'b0;
        await_issue("pz_resume", e, n);
        check("pz_resume_latency", 32'(n), 32'd1);
        exec_done = 4'b0010;
        tick();
        exec_done = 4'b0000;

        // Reset mid-busy drops grant and pending requests
        do_reset();
        sb_q.push_back(0);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        await_issue("mr_first", e, n);
        tick();
        req = 4'b1100;
        tick();
        req = 4'b0000;
        check("mr_busy", 32'(busy), 32'd1);
        exec_set_v = 4'b0001;
        reset = 1'b1;
        #1;
        check("mr_cm_gated", 32'(cm_set_v), 32'd0);
        tick();
        check("mr_idle", 32'({busy, exec_v}), 32'd0);
        reset = 1'b0;
        exec_set_v = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("mr_quiet%0d", i), 32'({busy, exec_v}), 32'd0);
        end
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        // Gravity period 8 and counter freeze under pause
        reset_g = 1'b0;
        next_pulse_g(n);
        check("grav_first_seen", 32'(exec_v_g), 32'b0001);
        next_pulse_g(n);
        check("grav_period_a", 32'(n), 32'd8);
        check("grav_onehot_a", 32'(exec_v_g), 32'b0001);
        next_pulse_g(n);
        check("grav_period_b", 32'(n), 32'd8);
        pause_g = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("grav_paused%0d", i), 32'(exec_v_g), 32'd0);
        end
        pause_g = 1'b0;
        next_pulse_g(n);
        check("grav_frozen_resume", 32'(n), 32'd8);
        check("grav_resume_onehot", 32'(exec_v_g), 32'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
